tpu_seq: RTL and testbench

Sequencer for a DIM×DIM systolic array of `tpumac` cells. Drives the array-wide `en`/`WrEn` controls, generates the skewed A/B injection window, optionally zero-clears the C accumulators, and steps result readout. One `start` runs one full matrix-multiply pass. Sits between the host command interface and the MAC array plus its A/B/C buffers.

---
 rtl/tpu_seq.sv | 138 +++++++++++++
 tb/tb_tpu_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_seq.sv
// Purpose: sequences one systolic matrix-multiply pass: optional C clear, skewed A/B compute window, C row readout.
// Latency: start edge to done = 4*DIM-1 cycles (5*DIM-1 with clear), plus one cycle per stalled COMPUTE cycle.
// Backpressure: stall freezes the compute step counter and gates en/a_valid/b_valid; start is ignored while busy.
module tpu_seq #(
    parameter int DIM = 8,
    parameter int KW  = $clog2(3*DIM),
    parameter int RW  = $clog2(DIM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clr_c,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic            en,
    output logic            WrEn,
    output logic            c_zero,
    output logic [RW-1:0]   crow,
    output logic [KW-1:0]   k,
    output logic [DIM-1:0]  a_valid,
    output logic [DIM-1:0]  b_valid,
    output logic            rd_valid
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_COMPUTE = 3'd2,
        S_READ    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Terminal counts: last C row, and last skewed compute step (3*DIM-3).
    localparam logic [KW-1:0] ROW_LAST = KW'(DIM - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(3*DIM - 3);

    state_t          state;
    state_t          state_nx;
    logic [KW-1:0]   cnt;
    logic [KW-1:0]   cnt_nx;
    logic [31:0]     cnt_ext;
    logic [DIM-1:0]  win;

    // State and step counter register; reset returns to IDLE with a cleared counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state, counter advance and output decode from the registered state/counter.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy     = 1'b0;
        done     = 1'b0;
        en       = 1'b0;
        WrEn     = 1'b0;
        c_zero   = 1'b0;
        crow     = '0;
        k        = '0;
        a_valid  = '0;
        b_valid  = '0;
        rd_valid = 1'b0;
        cnt_ext  = {{(32-KW){1'b0}}, cnt};
        win      = '0;

        // Row r (and column r) carries real operands while r <= k < r+DIM.
        for (int r = 0; r < DIM; r++) begin
            win[r] = (cnt_ext >= 32'(r)) && (cnt_ext < 32'(r + DIM));
        end

        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (start) begin
                    state_nx = clr_c ? S_CLEAR : S_COMPUTE;
                end
            end
            S_CLEAR: begin
                busy   = 1'b1;
                en     = 1'b1;
                WrEn   = 1'b1;
                c_zero = 1'b1;
                crow   = cnt[RW-1:0];
                if (cnt == ROW_LAST) begin
                    state_nx = S_COMPUTE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + KW'(1);
                end
            end
            S_COMPUTE: begin
                busy    = 1'b1;
                k       = cnt;
                en      = ~stall;
                a_valid = stall ? '0 : win;
                b_valid = stall ? '0 : win;
                // A stalled step is held and completes in the first unstalled cycle.
                if (!stall) begin
                    if (cnt == K_LAST) begin
                        state_nx = S_READ;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + KW'(1);
                    end
                end
            end
            S_READ: begin
                busy     = 1'b1;
                rd_valid = 1'b1;
                crow     = cnt[RW-1:0];
                if (cnt == ROW_LAST) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + KW'(1);
                end
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_tpu_seq.sv
// Bench for tpu_seq at DIM=4: a queue-of-phases reference model plus an idealised MAC array fed by the DUT controls.
// Checks every cycle against the model, plus literal timing expectations for the directed scenarios.
// Random phase mixes start, clr_c, stall and occasional reset.
module tb_tpu_seq;

    localparam int D  = 4;
    localparam int KW = $clog2(3*D);
    localparam int RW = $clog2(D);

    localparam int K_CLR = 0;
    localparam int K_CMP = 1;
    localparam int K_RD  = 2;
    localparam int K_DN  = 3;

    logic           clk = 1'b0;
    logic           rst, start, clr_c, stall;
    logic           busy, done, en, WrEn, c_zero, rd_valid;
    logic [RW-1:0]  crow;
    logic [KW-1:0]  k;
    logic [D-1:0]   a_valid, b_valid;

    tpu_seq #(.DIM(D)) dut (
        .clk(clk), .rst(rst), .start(start), .clr_c(clr_c), .stall(stall),
        .busy(busy), .done(done), .en(en), .WrEn(WrEn), .c_zero(c_zero),
        .crow(crow), .k(k), .a_valid(a_valid), .b_valid(b_valid), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference: the remaining phases of the current pass, one entry per presented cycle.
    typedef struct { int kind; int idx; } item_t;
    item_t q[$];
    bit    pass_clr = 1'b0;

    // Operands of the current pass, golden product, and idealised array state.
    logic signed [7:0]  ma [D][D];
    logic signed [7:0]  mb [D][D];
    logic signed [15:0] gold [D][D];
    logic signed [15:0] acc [D][D];
    logic signed [15:0] ar [D][D];
    logic signed [15:0] br [D][D];

    // DUT control outputs captured during the previous cycle, consumed at the next edge.
    logic           s_en = 1'b0, s_wr = 1'b0, s_cz = 1'b0;
    logic [RW-1:0]  s_crow = '0;
    logic [KW-1:0]  s_k = '0;
    logic [D-1:0]   s_av = '0, s_bv = '0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic new_operands();
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) begin
                ma[r][c] = 8'($urandom);
                mb[r][c] = 8'($urandom);
            end
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) begin
                logic signed [15:0] s;
                s = 16'sd0;
                for (int i = 0; i < D; i++) begin
                    logic signed [15:0] x, y;
                    x = ma[r][i];
                    y = mb[i][c];
                    s = s + x * y;
                end
                gold[r][c] = s;
            end
    endtask

    // Advance the phase queue with the inputs sampled at this edge.
    task automatic model_step();
        if (rst) begin
            q.delete();
        end else if (q.size() > 0) begin
            if (!(q[0].kind == K_CMP && stall)) void'(q.pop_front());
        end else if (start) begin
            if (clr_c) for (int i = 0; i < D; i++) q.push_back('{K_CLR, i});
            for (int i = 0; i <= 3*D-3; i++) q.push_back('{K_CMP, i});
            for (int i = 0; i < D; i++) q.push_back('{K_RD, i});
            q.push_back('{K_DN, 0});
            pass_clr = clr_c;
            new_operands();
        end
    endtask

    // Output-stationary array: A flows right, B flows down, products accumulate while enabled.
    task automatic array_step();
        if (s_en) begin
            for (int r = D-1; r >= 0; r--)
                for (int c = D-1; c >= 0; c--) begin
                    logic signed [15:0] ain, bin;
                    if (c == 0) ain = s_av[r] ? 16'(ma[r][int'(s_k) - r]) : 16'sd0;
                    else        ain = ar[r][c-1];
                    if (r == 0) bin = s_bv[c] ? 16'(mb[int'(s_k) - c][c]) : 16'sd0;
                    else        bin = br[r-1][c];
                    if (!s_wr) acc[r][c] = acc[r][c] + ain * bin;
                    ar[r][c] = ain;
                    br[r][c] = bin;
                end
        end
        if (s_wr && s_cz)
            for (int c = 0; c < D; c++) acc[s_crow][c] = 16'sd0;
    endtask

    task automatic compare();
        bit          have;
        item_t       h;
        logic [D-1:0] ew;
        have = (q.size() > 0);
        h    = have ? q[0] : '{-1, 0};
        for (int r = 0; r < D; r++)
            ew[r] = have && h.kind == K_CMP && !stall && r <= h.idx && h.idx < r + D;
        chk("busy",     int'(busy),     int'(have));
        chk("done",     int'(done),     int'(h.kind == K_DN));
        chk("en",       int'(en),       int'(h.kind == K_CLR || (h.kind == K_CMP && !stall)));
        chk("WrEn",     int'(WrEn),     int'(h.kind == K_CLR));
        chk("c_zero",   int'(c_zero),   int'(h.kind == K_CLR));
        chk("rd_valid", int'(rd_valid), int'(h.kind == K_RD));
        chk("a_valid",  int'(a_valid),  int'(ew));
        chk("b_valid",  int'(b_valid),  int'(ew));
        if (h.kind == K_CMP) chk("k", int'(k), h.idx);
        if (h.kind == K_CLR || h.kind == K_RD) chk("crow", int'(crow), h.idx);
        if (h.kind == K_RD && pass_clr)
            for (int c = 0; c < D; c++)
                chk("c_row", int'(acc[h.idx][c]), int'(gold[h.idx][c]));
    endtask

    // One clock cycle: edge updates, then drive this cycle's inputs, then check.
    task automatic cycle(input logic st, input logic cl, input logic sl, input logic rs);
        @(posedge clk);
        array_step();
        model_step();
        #1;
        start = st; clr_c = cl; stall = sl; rst = rs;
        #1;
        compare();
        s_en = en; s_wr = WrEn; s_cz = c_zero; s_crow = crow;
        s_k = k; s_av = a_valid; s_bv = b_valid;
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; clr_c = 1'b0; stall = 1'b0;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < D; c++) begin
                acc[r][c] = '0; ar[r][c] = '0; br[r][c] = '0;
            end

        // Reset state
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_en",   int'(en),   0);
        chk("rst_k",    int'(k),    0);
        chk("rst_done", int'(done), 0);

        // Full pass with clear
        cycle(1, 1, 0, 0);
        for (int n = 1; n <= 20; n++) begin
            cycle(0, 0, 0, 0);
            if (n <= 4) begin
                chk("fp_wren", int'(WrEn), 1);
                chk("fp_czero", int'(c_zero), 1);
                chk("fp_clr_crow", int'(crow), n - 1);
            end else if (n <= 14) begin
                chk("fp_k", int'(k), n - 5);
            end else if (n <= 18) begin
                chk("fp_rd_valid", int'(rd_valid), 1);
                chk("fp_rd_crow", int'(crow), n - 15);
            end else if (n == 19) begin
                chk("fp_done19", int'(done), 1);
            end else begin
                chk("fp_idle20", int'(busy), 0);
            end
        end

        // Skew window without clear
        cycle(1, 0, 0, 0);
        for (int n = 1; n <= 16; n++) begin
            cycle(0, 0, 0, 0);
            if (n == 1) chk("skew_k0", int'(a_valid), 1);
            if (n == 4) chk("skew_k3", int'(a_valid), 15);
            if (n == 7) chk("skew_k6", int'(a_valid), 8);
            if (n == 8) chk("skew_k7", int'(a_valid), 0);
            chk("skew_done15", int'(done), int'(n == 15));
        end

        // Three stalled cycles at k=2
        cycle(1, 0, 0, 0);
        for (int n = 1; n <= 19; n++) begin
            logic sl;
            sl = (n >= 3 && n <= 5);
            cycle(0, 0, sl, 0);
            if (sl) begin
                chk("stall_k", int'(k), 2);
                chk("stall_en", int'(en), 0);
                chk("stall_av", int'(a_valid), 0);
                chk("stall_bv", int'(b_valid), 0);
            end
            chk("stall_done18", int'(done), int'(n == 18));
        end

        // Start pulses during READ and DONE are ignored
        ndone = 0;
        cycle(1, 0, 0, 0);
        for (int n = 1; n <= 17; n++) begin
            cycle(logic'(n == 13 || n == 15), 0, 0, 0);
            if (done) ndone++;
            if (n == 16) chk("sb_busy16", int'(busy), 0);
        end
        chk("sb_one_done", ndone, 1);

        // Reset mid-COMPUTE at k=5, then a normal pass with clear
        cycle(1, 0, 0, 0);
        for (int n = 1; n <= 6; n++) begin
            cycle(0, 0, 0, logic'(n == 6));
            if (n == 6) chk("mr_k5", int'(k), 5);
        end
        cycle(0, 0, 0, 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_en",   int'(en),   0);
        chk("mr_wren", int'(WrEn), 0);
        chk("mr_done", int'(done), 0);
        chk("mr_k",    int'(k),    0);
        cycle(1, 1, 0, 0);
        for (int n = 1; n <= 20; n++) begin
            cycle(0, 0, 0, 0);
            chk("mr_pass_done19", int'(done), int'(n == 19));
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 299) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
